trigger_sequencer: RTL and testbench

Arming and trigger front-end for the glitch pulser. On an arm command from the UART handler it optionally holds the target in reset, waits for a configured edge on the external trigger (or fires immediately), then issues a single-cycle enable strobe to the pulser and waits for it to finish. It also drives `target_reset_o` at the top level and reports armed, busy, timeout and shot-count status back to the UART handler.

---
 rtl/glitch_pkg.sv | 44 ++++
 rtl/trigger_sync.sv | 34 +++
 rtl/trigger_sequencer.sv | 167 ++++++++++++++++
 tb/tb_trigger_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch pulser trigger front-end.
package glitch_pkg;

    localparam int unsigned CFG_W         = 16;
    localparam int unsigned WAIT_W        = 24;
    localparam int unsigned SHOT_W        = 8;
    localparam int unsigned TIMEOUT_SHIFT = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_FIRE      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } seq_state_t;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_ANY  = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    // Configuration captured at arm time
    typedef struct packed {
        logic [1:0]       edge_sel;
        logic [CFG_W-1:0] timeout;
    } arm_cfg_t;

    // Qualify the synchronised edge against the selected edge mode.
    // A rise can only coincide with a high level and a fall with a low one,
    // so the level picks which detector applies for either-edge mode.
    function automatic logic edge_hit(input logic [1:0] sel, input logic rise,
                                      input logic fall, input logic level);
        logic hit;
        hit = 1'b0;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_ANY:  hit = level ? rise : fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/trigger_sync.sv
// Synchroniser chain and edge detector for the asynchronous external trigger.
module trigger_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Flop chain plus previous-sample register, both running every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], trigger_i};
            r_prev <= w_level;
        end
    end

    assign rise_o  = w_level & ~r_prev;
    assign fall_o  = ~w_level & r_prev;
    assign level_o = w_level;

endmodule

// File: rtl/trigger_sequencer.sv
// Arm / optional target reset / trigger wait / fire sequencer for the glitch pulser.
module trigger_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [1:0]        edge_sel_i,
    input  logic              reset_en_i,
    input  logic [15:0]       reset_cycles_i,
    input  logic [15:0]       timeout_i,
    input  logic              trigger_i,
    input  logic              pulser_ready_i,
    output logic              pulse_en_o,
    output logic              target_reset_o,
    output logic              armed_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [7:0]        shot_count_o
);

    seq_state_t          r_state;
    arm_cfg_t            r_cfg;
    logic [CFG_W-1:0]    r_rst_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_done_first;
    logic                r_pulse_en;
    logic                r_target_reset;
    logic                r_armed;
    logic                r_busy;
    logic                r_timeout;
    logic [SHOT_W-1:0]   r_shot_count;

    logic                w_rise;
    logic                w_fall;
    logic                w_level;
    logic                w_hit;
    logic [WAIT_W-1:0]   w_wait_next;
    logic                w_timeout_en;
    logic                w_timeout_hit;

    trigger_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trigger_sync (
        .clk       (clk),
        .rst       (rst),
        .trigger_i (trigger_i),
        .rise_o    (w_rise),
        .fall_o    (w_fall),
        .level_o   (w_level)
    );

    // Edge qualification and timeout compare against the next wait count
    always_comb begin
        w_hit         = edge_hit(r_cfg.edge_sel, w_rise, w_fall, w_level);
        w_wait_next   = r_wait_cnt + WAIT_W'(1);
        w_timeout_en  = (r_cfg.timeout != '0);
        w_timeout_hit = w_timeout_en &&
                        (w_wait_next[WAIT_W-1:TIMEOUT_SHIFT] == r_cfg.timeout);
    end

    // Sequencer FSM with all status outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cfg          <= '0;
            r_rst_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_done_first   <= 1'b0;
            r_pulse_en     <= 1'b0;
            r_target_reset <= 1'b0;
            r_armed        <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout      <= 1'b0;
            r_shot_count   <= '0;
        end else if (abort_i) begin
            r_state        <= ST_IDLE;
            r_pulse_en     <= 1'b0;
            r_target_reset <= 1'b0;
            r_armed        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_pulse_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (arm_i) begin
                        r_cfg.edge_sel <= edge_sel_i;
                        r_cfg.timeout  <= timeout_i;
                        r_timeout      <= 1'b0;
                        r_busy         <= 1'b1;
                        if (reset_en_i && (reset_cycles_i != '0)) begin
                            r_state        <= ST_RESET;
                            r_rst_cnt      <= reset_cycles_i;
                            r_target_reset <= 1'b1;
                        end else if (edge_sel_i == EDGE_NONE) begin
                            r_state <= ST_FIRE;
                        end else begin
                            r_state    <= ST_WAIT_TRIG;
                            r_wait_cnt <= '0;
                            r_armed    <= 1'b1;
                        end
                    end
                end
                ST_RESET: begin
                    if (r_rst_cnt == CFG_W'(1)) begin
                        r_target_reset <= 1'b0;
                        if (r_cfg.edge_sel == EDGE_NONE) begin
                            r_state <= ST_FIRE;
                        end else begin
                            r_state    <= ST_WAIT_TRIG;
                            r_wait_cnt <= '0;
                            r_armed    <= 1'b1;
                        end
                    end else begin
                        r_rst_cnt <= r_rst_cnt - CFG_W'(1);
                    end
                end
                ST_WAIT_TRIG: begin
                    if (w_hit) begin
                        r_state <= ST_FIRE;
                        r_armed <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_state   <= ST_IDLE;
                        r_armed   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else if (w_timeout_en || (r_wait_cnt != '1)) begin
                        r_wait_cnt <= w_wait_next;
                    end
                end
                ST_FIRE: begin
                    if (pulser_ready_i) begin
                        r_state      <= ST_WAIT_DONE;
                        r_pulse_en   <= 1'b1;
                        r_done_first <= 1'b1;
                        r_shot_count <= r_shot_count + SHOT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (r_done_first) begin
                        r_done_first <= 1'b0;
                    end else if (pulser_ready_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_armed        <= 1'b0;
                    r_busy         <= 1'b0;
                    r_target_reset <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_en_o     = r_pulse_en;
    assign target_reset_o = r_target_reset;
    assign armed_o        = r_armed;
    assign busy_o         = r_busy;
    assign timeout_o      = r_timeout;
    assign shot_count_o   = r_shot_count;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: edge-mode table plus corner-case sequences.
module tb_trigger_sequencer;

    logic        clk;
    logic        rst;
    logic        arm_i;
    logic        abort_i;
    logic [1:0]  edge_sel_i;
    logic        reset_en_i;
    logic [15:0] reset_cycles_i;
    logic [15:0] timeout_i;
    logic        trigger_i;
    logic        pulser_ready_i;
    logic        pulse_en_o;
    logic        target_reset_o;
    logic        armed_o;
    logic        busy_o;
    logic        timeout_o;
    logic [7:0]  shot_count_o;

    int total;
    int bad;
    int exp_shots;

    trigger_sequencer #(.SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .edge_sel_i     (edge_sel_i),
        .reset_en_i     (reset_en_i),
        .reset_cycles_i (reset_cycles_i),
        .timeout_i      (timeout_i),
        .trigger_i      (trigger_i),
        .pulser_ready_i (pulser_ready_i),
        .pulse_en_o     (pulse_en_o),
        .target_reset_o (target_reset_o),
        .armed_o        (armed_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .shot_count_o   (shot_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] sel;
        logic       trig_init;
        logic       trig_final;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the arm edge
    task automatic do_arm(input logic [1:0] sel, input logic ren,
                          input logic [15:0] rcyc, input logic [15:0] tmo);
        edge_sel_i     = sel;
        reset_en_i     = ren;
        reset_cycles_i = rcyc;
        timeout_i      = tmo;
        arm_i          = 1'b1;
        @(negedge clk);
        arm_i          = 1'b0;
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
    endtask

    task automatic wait_pulse(output int lat, input int maxc);
        lat = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (pulse_en_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while (busy_o && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int lat;
        int rc;
        int pulse_seen;

        total = 0;
        bad = 0;
        exp_shots = 0;

        rst = 1'b0;
        arm_i = 1'b0;
        abort_i = 1'b0;
        edge_sel_i = 2'b00;
        reset_en_i = 1'b0;
        reset_cycles_i = 16'd0;
        timeout_i = 16'd0;
        trigger_i = 1'b0;
        pulser_ready_i = 1'b1;

        vecs[0] = '{sel: 2'b00, trig_init: 1'b0, trig_final: 1'b1, exp_lat: 4};
        vecs[1] = '{sel: 2'b01, trig_init: 1'b1, trig_final: 1'b0, exp_lat: 4};
        vecs[2] = '{sel: 2'b10, trig_init: 1'b0, trig_final: 1'b1, exp_lat: 4};
        vecs[3] = '{sel: 2'b10, trig_init: 1'b1, trig_final: 1'b0, exp_lat: 4};
        vecs[4] = '{sel: 2'b00, trig_init: 1'b1, trig_final: 1'b0, exp_lat: 0};
        vecs[5] = '{sel: 2'b01, trig_init: 1'b0, trig_final: 1'b1, exp_lat: 0};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({pulse_en_o, target_reset_o, armed_o, busy_o, timeout_o, shot_count_o}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Edge-mode table: arm, wait 10 cycles, move the trigger
        for (int v = 0; v < 6; v++) begin
            trigger_i = vecs[v].trig_init;
            repeat (6) @(negedge clk);
            do_arm(vecs[v].sel, 1'b0, 16'd0, 16'd0);
            check($sformatf("v%0d_armed", v), 32'(armed_o), 32'd1);
            check($sformatf("v%0d_busy", v), 32'(busy_o), 32'd1);
            repeat (10) @(negedge clk);
            trigger_i = vecs[v].trig_final;
            wait_pulse(lat, 12);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (vecs[v].exp_lat != 0) begin
                exp_shots++;
                @(negedge clk);
                check($sformatf("v%0d_pulse_width", v), 32'(pulse_en_o), 32'd0);
                check($sformatf("v%0d_shots", v), 32'(shot_count_o), 32'(exp_shots));
                @(negedge clk);
                check($sformatf("v%0d_done_idle", v), 32'(busy_o), 32'd0);
            end else begin
                check($sformatf("v%0d_still_armed", v), 32'(armed_o), 32'd1);
                do_abort();
                check($sformatf("v%0d_abort_idle", v), 32'(busy_o), 32'd0);
                check($sformatf("v%0d_shots", v), 32'(shot_count_o), 32'(exp_shots));
            end
        end

        // Reset phase of 5 cycles, rise during reset ignored, later fall fires
        trigger_i = 1'b0;
        repeat (6) @(negedge clk);
        do_arm(2'b01, 1'b1, 16'd5, 16'd0);
        check("rst_target_high", 32'(target_reset_o), 32'd1);
        trigger_i = 1'b1;
        rc = 0;
        pulse_seen = 0;
        while (target_reset_o && rc < 20) begin
            rc++;
            if (pulse_en_o) pulse_seen = 1;
            @(negedge clk);
        end
        check("rst_length", 32'(rc), 32'd5);
        check("rst_no_pulse", 32'(pulse_seen), 32'd0);
        check("rst_then_armed", 32'(armed_o), 32'd1);
        repeat (5) @(negedge clk);
        check("rst_rise_ignored", 32'(armed_o), 32'd1);
        trigger_i = 1'b0;
        wait_pulse(lat, 12);
        check("rst_fall_latency", 32'(lat), 32'd4);
        exp_shots++;
        wait_idle("rst_idle", 10);
        check("rst_shots", 32'(shot_count_o), 32'(exp_shots));

        // Timeout after 512 cycles in WAIT_TRIG, cleared by the next arm
        repeat (3) @(negedge clk);
        do_arm(2'b00, 1'b0, 16'd0, 16'd2);
        rc = 0;
        pulse_seen = 0;
        while (armed_o && rc < 600) begin
            rc++;
            if (pulse_en_o) pulse_seen = 1;
            @(negedge clk);
        end
        check("tmo_wait_cycles", 32'(rc), 32'd512);
        check("tmo_flag", 32'(timeout_o), 32'd1);
        check("tmo_idle", 32'(busy_o), 32'd0);
        check("tmo_no_pulse", 32'(pulse_seen), 32'd0);
        repeat (4) @(negedge clk);
        check("tmo_sticky", 32'(timeout_o), 32'd1);
        do_arm(2'b11, 1'b0, 16'd0, 16'd0);
        check("tmo_cleared", 32'(timeout_o), 32'd0);
        exp_shots++;
        wait_idle("tmo_rearm_idle", 10);

        // Pulser busy: hold in FIRE until ready rises
        pulser_ready_i = 1'b0;
        do_arm(2'b11, 1'b0, 16'd0, 16'd0);
        pulse_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (pulse_en_o || !busy_o) pulse_seen = 1;
            @(negedge clk);
        end
        check("busy_hold", 32'(pulse_seen), 32'd0);
        check("busy_shots_held", 32'(shot_count_o), 32'(exp_shots));
        pulser_ready_i = 1'b1;
        @(negedge clk);
        check("busy_fire", 32'(pulse_en_o), 32'd1);
        exp_shots++;
        check("busy_shots", 32'(shot_count_o), 32'(exp_shots));
        wait_idle("busy_idle", 10);

        // Abort with simultaneous arm during RESET
        do_arm(2'b00, 1'b1, 16'd100, 16'd0);
        repeat (3) @(negedge clk);
        check("abort_in_reset", 32'(target_reset_o), 32'd1);
        abort_i = 1'b1;
        arm_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        arm_i = 1'b0;
        check("abort_idle", 32'(busy_o), 32'd0);
        check("abort_target_low", 32'(target_reset_o), 32'd0);
        check("abort_shots", 32'(shot_count_o), 32'(exp_shots));
        @(negedge clk);
        check("abort_arm_dropped", 32'(busy_o), 32'd0);

        // Mid-operation reset for one edge clears every output
        do_arm(2'b00, 1'b1, 16'd50, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_outputs",
              32'({pulse_en_o, target_reset_o, armed_o, busy_o, timeout_o, shot_count_o}), 32'd0);
        exp_shots = 0;

        // 256 immediate fires wrap the shot counter
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            do_arm(2'b11, 1'b0, 16'd0, 16'd0);
            wait_idle($sformatf("wrap_idle_%0d", i), 10);
            if (i == 254) check("wrap_255", 32'(shot_count_o), 32'd255);
        end
        check("wrap_zero", 32'(shot_count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
